// File: rtl/tpu_pkg.sv
// Shared TPU definitions: sequencer state encoding and default datapath widths
// used by the accumulator, the row sequencer and the unified buffer.
package tpu_pkg;

  localparam int unsigned TPU_DATA_W = 32;
  localparam int unsigned TPU_ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/acc_row_sequencer_if.sv
// Handshake bundle between the array column outputs, the row sequencer and
// the unified-buffer write port.
interface acc_row_sequencer_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  // Sequencer side
  modport master (
    input  in_valid, in_data, wr_ready,
    output in_ready, wr_valid, wr_addr, wr_data
  );

  // Array / buffer side
  modport slave (
    output in_valid, in_data, wr_ready,
    input  in_ready, wr_valid, wr_addr, wr_data
  );
endinterface

// File: rtl/acc_row_buf.sv
// COLS x DATA_W row register file: one write port, one combinational read
// port and a synchronous clear.
module acc_row_buf #(
  parameter int unsigned COLS   = 2,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned IDX_W = $clog2(COLS)
) (
  input  logic              clk,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  widx_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  ridx_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [COLS];

  // Store one column word per enabled cycle; clear wipes the whole row
  always_ff @(posedge clk) begin
    if (clr_i) begin
      for (int unsigned i = 0; i < COLS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[widx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/acc_row_sequencer.sv
// Row sequencer: gathers COLS result words into a row register, drains the
// row to the unified buffer over valid/ready, repeats for the programmed row
// count and pulses done at the end.
module acc_row_sequencer
  import tpu_pkg::*;
#(
  parameter int unsigned COLS   = 2,
  parameter int unsigned DATA_W = TPU_DATA_W,
  parameter int unsigned ADDR_W = TPU_ADDR_W,
  parameter int unsigned ROWS_W = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ROWS_W-1:0]        num_rows,
  input  logic [ADDR_W-1:0]        base_addr,
  acc_row_sequencer_if.master      bus,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned CNT_W = $clog2(COLS);
  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(COLS - 1);

  seq_state_t          state_q, state_d;
  logic [CNT_W-1:0]    col_cnt_q, col_cnt_d;
  logic [ROWS_W-1:0]   row_cnt_q, row_cnt_d;
  logic [ROWS_W-1:0]   rows_q, rows_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ROWS_W:0]     row_inc;

  logic                in_ready_q, in_ready_d;
  logic                wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                buf_we;
  logic [DATA_W-1:0]   buf_rdata;

  assign buf_we  = (state_q == FILL) && bus.in_valid && in_ready_q;
  assign row_inc = {1'b0, row_cnt_q} + 1'b1;

  acc_row_buf #(
    .COLS   (COLS),
    .DATA_W (DATA_W)
  ) u_row_buf (
    .clk     (clk),
    .clr_i   (reset),
    .we_i    (buf_we),
    .widx_i  (col_cnt_q),
    .wdata_i (bus.in_data),
    .ridx_i  (col_cnt_d),
    .rdata_o (buf_rdata)
  );

  // State and counter sequencing
  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    rows_d    = rows_q;
    base_d    = base_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          rows_d    = (num_rows == '0) ? ROWS_W'(1) : num_rows;
          base_d    = base_addr;
          col_cnt_d = '0;
          row_cnt_d = '0;
          state_d   = FILL;
        end
      end
      FILL: begin
        if (bus.in_valid && in_ready_q) begin
          if (col_cnt_q == LAST_COL) begin
            col_cnt_d = '0;
            state_d   = DRAIN;
          end else begin
            col_cnt_d = col_cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (wr_valid_q && bus.wr_ready) begin
          if (col_cnt_q == LAST_COL) begin
            col_cnt_d = '0;
            row_cnt_d = row_inc[ROWS_W-1:0];
            state_d   = (row_inc == {1'b0, rows_q}) ? DONE : FILL;
          end else begin
            col_cnt_d = col_cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are derived from the next state and next counters so
  // they line up with state_q; the write word is read from the row register
  // at the next column index, which keeps it stable while wr_ready is low.
  always_comb begin
    in_ready_d = (state_d == FILL);
    wr_valid_d = (state_d == DRAIN);
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
    wr_addr_d  = '0;
    wr_data_d  = '0;
    if (state_d == DRAIN) begin
      wr_addr_d = base_d + ADDR_W'(row_cnt_d) * ADDR_W'(COLS) + ADDR_W'(col_cnt_d);
      wr_data_d = buf_rdata;
    end
  end

  // State, counters and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      col_cnt_q  <= '0;
      row_cnt_q  <= '0;
      rows_q     <= '0;
      base_q     <= '0;
      in_ready_q <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_cnt_q  <= col_cnt_d;
      row_cnt_q  <= row_cnt_d;
      rows_q     <= rows_d;
      base_q     <= base_d;
      in_ready_q <= in_ready_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.wr_valid = wr_valid_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
